// File: rtl/tart_readout_pkg.sv
// ---------------------------------------------------------------------------
// tart_readout_pkg
// Shared definitions for the TX FIFO readout path. The readout top level and
// its word shifter import this package. The word-count default is also the
// fill threshold that the acquisition/SDRAM scheduler uses.
// Contents:
//   DEFAULT_DATA_WIDTH  - default TX FIFO word width (must be a multiple of 8)
//   DEFAULT_TOTAL_WORDS - words delivered before readout is complete
//   readout_state_e     - readout FSM states, with fixed 3-bit encodings
//   idx_width()         - width of a byte index for a given bytes-per-word
// ---------------------------------------------------------------------------
package tart_readout_pkg;

  localparam int          DEFAULT_DATA_WIDTH  = 24;
  localparam logic [21:0] DEFAULT_TOTAL_WORDS = 22'h1FFFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    READ      = 3'd2,
    LATCH     = 3'd3,
    SEND      = 3'd4,
    DONE      = 3'd5
  } readout_state_e;

  // A one-byte word still needs a 1-bit index so that the vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tart_word_shifter.sv
// ---------------------------------------------------------------------------
// tart_word_shifter
// Parallel-load register that shifts left by 8. It presents one FIFO word as
// a byte stream, most significant byte first, and tracks which byte of the
// word is currently on the output.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - capture load_data and restart at byte 0
//   shift      - move to the next byte (ignored when load is high)
//   load_data  - FIFO word to capture
//   top_byte   - byte currently presented (top 8 bits of the register)
//   last_byte  - high while the final byte of the word is presented
// ---------------------------------------------------------------------------
module tart_word_shifter
  import tart_readout_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [7:0]            top_byte,
  output logic                  last_byte
);

  localparam int IDX_W = idx_width(BYTES_PER_WORD);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;

  // Load has priority over shift, so a fresh word always starts at byte 0.
  always_comb begin
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    if (load) begin
      shreg_d    = load_data;
      byte_idx_d = '0;
    end else if (shift) begin
      shreg_d    = shreg_q << 8;
      byte_idx_d = byte_idx_q + 1'b1;
    end
  end

  // Register update. Reset clears the register, so the presented byte reads
  // 8'h00 until the first word is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign top_byte  = shreg_q[DATA_WIDTH-1 -: 8];
  assign last_byte = (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/tart_tx_readout.sv
// ---------------------------------------------------------------------------
// tart_tx_readout
// Drains the baseband TX FIFO and hands each word to the SPI slave as a byte
// stream, using a valid/ack handshake. Readout starts once the scheduler
// reports that the first read is possible. The block then counts delivered
// words, stops after TOTAL_WORDS, and flags acks that arrive while no byte is
// offered.
// Ports:
//   bb_clk, rst              - clock and synchronous active-high reset
//   tx_ready_for_first_read  - scheduler level that enables readout (IDLE only)
//   tx_empty, tx_rd_en       - FIFO empty flag and one-cycle read strobe
//   tx_dout                  - FIFO data, valid the cycle after tx_rd_en
//   spi_byte, spi_byte_valid - byte offered to the SPI slave
//   spi_byte_ack             - SPI slave consumed spi_byte (one bb_clk pulse)
//   word_cnt                 - words fully delivered
//   readout_done             - all TOTAL_WORDS delivered
//   underrun                 - sticky; an ack arrived while no byte was valid
// ---------------------------------------------------------------------------
module tart_tx_readout
  import tart_readout_pkg::*;
#(
  parameter int          DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int          BYTES_PER_WORD = DATA_WIDTH / 8,
  parameter logic [21:0] TOTAL_WORDS    = DEFAULT_TOTAL_WORDS
) (
  input  logic                  bb_clk,
  input  logic                  rst,
  input  logic                  tx_ready_for_first_read,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  input  logic [DATA_WIDTH-1:0] tx_dout,
  output logic [7:0]            spi_byte,
  output logic                  spi_byte_valid,
  input  logic                  spi_byte_ack,
  output logic [21:0]           word_cnt,
  output logic                  readout_done,
  output logic                  underrun
);

  readout_state_e state_q, state_d;
  logic           rd_en_q, rd_en_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;
  logic [21:0]    word_cnt_q, word_cnt_d;

  logic           load;
  logic           shift;
  logic           last_byte;
  logic [7:0]     top_byte;

  tart_word_shifter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_shifter (
    .clk       (bb_clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (tx_dout),
    .top_byte  (top_byte),
    .last_byte (last_byte)
  );

  // Next-state and counter logic. The strobe, valid and done flags come from
  // the next state, so each flop matches the state it belongs to.
  // An ack without a valid byte only sets underrun; it never moves the FSM.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    underrun_d = underrun_q;
    load       = 1'b0;
    shift      = 1'b0;

    if (spi_byte_ack && !valid_q) begin
      underrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_ready_for_first_read) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (!tx_empty) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (spi_byte_ack) begin
          if (last_byte) begin
            word_cnt_d = word_cnt_q + 22'd1;
            state_d    = (word_cnt_d == TOTAL_WORDS) ? DONE : WAIT_DATA;
          end else begin
            shift = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d = (state_d == READ);
    valid_d = (state_d == SEND);
    done_d  = (state_d == DONE);
  end

  // State and output registers. Reset abandons any partially sent word.
  always_ff @(posedge bb_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign tx_rd_en       = rd_en_q;
  assign spi_byte       = top_byte;
  assign spi_byte_valid = valid_q;
  assign word_cnt       = word_cnt_q;
  assign readout_done   = done_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_tart_tx_readout.sv
// ---------------------------------------------------------------------------
// tb_tart_tx_readout
// Self-checking bench for tart_tx_readout. TOTAL_WORDS is set to 4 here.
// A FIFO model with read latency 1 drives the DUT. A reference model tracks,
// cycle by cycle, what the outputs must be: the byte stream in push order,
// the word count, done, and the sticky underrun flag. Directed scenarios add
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_tart_tx_readout;

  localparam logic [21:0] TW = 22'd4;

  logic        bb_clk;
  logic        rst;
  logic        tx_ready_for_first_read;
  logic        tx_empty;
  logic        tx_rd_en;
  logic [23:0] tx_dout;
  logic [7:0]  spi_byte;
  logic        spi_byte_valid;
  logic        spi_byte_ack;
  logic [21:0] word_cnt;
  logic        readout_done;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  // FIFO environment, owned by the negedge process. The stimulus only posts
  // requests.
  logic [23:0] fifo_q[$];
  logic [23:0] model_q[$];
  logic [23:0] push_buf[$];
  int          fifo_cnt   = 0;
  int          push_req   = 0;
  int          push_done  = 0;
  int          flush_req  = 0;
  int          flush_done = 0;
  int          rd_count   = 0;

  // Reference model: expected outputs for the current cycle.
  bit          m_rd        = 1'b0;
  bit          m_valid     = 1'b0;
  bit          m_done      = 1'b0;
  bit          m_under     = 1'b0;
  bit          m_zero_byte = 1'b1;
  logic [7:0]  m_byte      = 8'h00;
  int          m_words     = 0;
  bit          m_started   = 1'b0;
  bit          m_looking   = 1'b0;
  int          m_fetch     = 0;
  int          m_idx       = 0;
  logic [23:0] m_word      = '0;

  assign tx_empty = (fifo_cnt == 0);

  tart_tx_readout #(
    .DATA_WIDTH     (24),
    .BYTES_PER_WORD (3),
    .TOTAL_WORDS    (TW)
  ) dut (
    .bb_clk                  (bb_clk),
    .rst                     (rst),
    .tx_ready_for_first_read (tx_ready_for_first_read),
    .tx_empty                (tx_empty),
    .tx_rd_en                (tx_rd_en),
    .tx_dout                 (tx_dout),
    .spi_byte                (spi_byte),
    .spi_byte_valid          (spi_byte_valid),
    .spi_byte_ack            (spi_byte_ack),
    .word_cnt                (word_cnt),
    .readout_done            (readout_done),
    .underrun                (underrun)
  );

  initial bb_clk = 1'b0;
  always #5 bb_clk = ~bb_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge bb_clk);
    #1;
  endtask

  task automatic pushWord(input logic [23:0] w);
    push_buf.push_back(w);
    push_req++;
  endtask

  task automatic flushFifo();
    flush_req++;
  endtask

  // Inputs change 1 time unit after the rising edge. The negedge process
  // samples the DUT outputs, services the FIFO, and advances the model using
  // the inputs that the DUT will see on the next rising edge.
  always @(negedge bb_clk) begin
    logic [23:0] w;
    int          nxt_rd;

    checkOutput("tx_rd_en", {31'b0, tx_rd_en}, {31'b0, m_rd});
    checkOutput("spi_byte_valid", {31'b0, spi_byte_valid}, {31'b0, m_valid});
    if (m_valid) checkOutput("spi_byte", {24'b0, spi_byte}, {24'b0, m_byte});
    if (m_zero_byte) checkOutput("spi_byte_reset", {24'b0, spi_byte}, 32'h0);
    checkOutput("word_cnt", {10'b0, word_cnt}, m_words);
    checkOutput("readout_done", {31'b0, readout_done}, {31'b0, m_done});
    checkOutput("underrun", {31'b0, underrun}, {31'b0, m_under});
    checkOutput("overread", {31'b0, (tx_rd_en === 1'b1) && (fifo_q.size() == 0)}, 32'h0);

    // FIFO service: pop on the strobe; data is present for the following cycle.
    if (tx_rd_en === 1'b1) begin
      rd_count++;
      if (fifo_q.size() > 0) begin
        tx_dout = fifo_q.pop_front();
        fifo_cnt--;
      end
    end
    if (flush_done != flush_req) begin
      flush_done = flush_req;
      fifo_q.delete();
      model_q.delete();
      fifo_cnt = 0;
    end
    while (push_done < push_req) begin
      w = push_buf[push_done];
      push_done++;
      fifo_q.push_back(w);
      model_q.push_back(w);
      fifo_cnt++;
    end

    // Reference model.
    if (rst) begin
      m_rd = 0; m_valid = 0; m_done = 0; m_under = 0; m_zero_byte = 1;
      m_byte = 8'h00; m_words = 0; m_started = 0; m_looking = 0;
      m_fetch = 0; m_idx = 0;
    end else begin
      nxt_rd = 0;
      if (spi_byte_ack && !m_valid) m_under = 1;
      if (m_valid) begin
        if (spi_byte_ack) begin
          m_idx++;
          if (m_idx == 3) begin
            m_words++;
            m_valid = 0;
            m_idx   = 0;
            if (m_words == int'(TW)) m_done = 1;
            else m_looking = 1;
          end else begin
            m_byte = m_word[23 - 8*m_idx -: 8];
          end
        end
      end else if (!m_started) begin
        if (tx_ready_for_first_read) begin
          m_started = 1;
          m_looking = 1;
        end
      end else if (m_looking) begin
        if (fifo_q.size() > 0 && model_q.size() > 0) begin
          m_looking = 0;
          m_fetch   = 2;
          nxt_rd    = 1;
          m_word    = model_q.pop_front();
        end
      end else if (m_fetch > 0) begin
        m_fetch--;
        if (m_fetch == 0) begin
          m_valid     = 1;
          m_idx       = 0;
          m_byte      = m_word[23:16];
          m_zero_byte = 0;
        end
      end
      m_rd = (nxt_rd != 0);
    end
  end

  task automatic waitValid();
    int budget = 0;
    while (spi_byte_valid !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    checks++;
    if (spi_byte_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL valid_timeout actual=%b expected=1 at %0t", spi_byte_valid, $time);
    end
  endtask

  task automatic ackOne(input int gap, output logic [7:0] b);
    waitValid();
    repeat (gap) tick();
    b = spi_byte;
    spi_byte_ack = 1'b1;
    tick();
    spi_byte_ack = 1'b0;
  endtask

  task automatic ackWord(output logic [23:0] w);
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      ackOne(int'($urandom_range(0, 2)), b);
      w = {w[15:0], b};
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ready, input bit ack);
    rst                     = r;
    tx_ready_for_first_read = ready;
    spi_byte_ack            = ack;
  endtask

  initial begin
    logic [7:0]  b0, b1, b2;
    logic [23:0] w;
    int          rd0, d, start;

    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("reset_word_cnt", {10'b0, word_cnt}, 32'd0);
    checkOutput("reset_valid", {31'b0, spi_byte_valid}, 32'd0);
    checkOutput("reset_spi_byte", {24'b0, spi_byte}, 32'h00);
    rst = 1'b0;
    tick();

    // Single word, MSB first.
    rd0 = rd_count;
    pushWord(24'hA1B2C3);
    tx_ready_for_first_read = 1'b1;
    ackOne(0, b0);
    ackOne(1, b1);
    ackOne(0, b2);
    checkOutput("byte0", {24'b0, b0}, 32'hA1);
    checkOutput("byte1", {24'b0, b1}, 32'hB2);
    checkOutput("byte2", {24'b0, b2}, 32'hC3);
    checkOutput("word_cnt_1", {10'b0, word_cnt}, 32'd1);
    checkOutput("one_read", rd_count - rd0, 32'd1);
    checkOutput("valid_drop", {31'b0, spi_byte_valid}, 32'd0);

    // Empty FIFO for 50 cycles, then data: valid 3 cycles later.
    rd0 = rd_count;
    repeat (50) tick();
    checkOutput("no_read_empty", rd_count - rd0, 32'd0);
    pushWord(24'h5A6B7C);
    d = 0;
    while (spi_byte_valid !== 1'b1 && d < 20) begin
      tick();
      d++;
    end
    checkOutput("latency3", d, 32'd3);
    ackWord(w);
    checkOutput("word2", {8'b0, w}, 32'h5A6B7C);
    checkOutput("word_cnt_2", {10'b0, word_cnt}, 32'd2);

    // Ack while no byte is valid.
    spi_byte_ack = 1'b1;
    tick();
    spi_byte_ack = 1'b0;
    checkOutput("underrun_set", {31'b0, underrun}, 32'd1);
    checkOutput("underrun_cnt", {10'b0, word_cnt}, 32'd2);
    repeat (5) tick();
    checkOutput("underrun_sticky", {31'b0, underrun}, 32'd1);

    // Reset after the second byte of a word.
    pushWord(24'h112233);
    ackOne(0, b0);
    ackOne(0, b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mid_rst_rd", {31'b0, tx_rd_en}, 32'd0);
    checkOutput("mid_rst_valid", {31'b0, spi_byte_valid}, 32'd0);
    checkOutput("mid_rst_byte", {24'b0, spi_byte}, 32'h00);
    checkOutput("mid_rst_cnt", {10'b0, word_cnt}, 32'd0);
    checkOutput("mid_rst_done", {31'b0, readout_done}, 32'd0);
    checkOutput("mid_rst_under", {31'b0, underrun}, 32'd0);
    rst = 1'b0;
    rd0 = rd_count;
    pushWord(24'hC0FFEE);
    repeat (10) tick();
    checkOutput("no_start_wo_ready", rd_count - rd0, 32'd0);
    tx_ready_for_first_read = 1'b1;
    ackWord(w);
    checkOutput("restart_word", {8'b0, w}, 32'hC0FFEE);
    checkOutput("restart_cnt", {10'b0, word_cnt}, 32'd1);

    // Ack held high for three cycles.
    pushWord(24'h9ABCDE);
    waitValid();
    spi_byte_ack = 1'b1;
    repeat (3) tick();
    spi_byte_ack = 1'b0;
    checkOutput("held_ack_cnt", {10'b0, word_cnt}, 32'd2);
    checkOutput("held_ack_under", {31'b0, underrun}, 32'd0);

    // TOTAL_WORDS = 4 with 6 words queued.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    flushFifo();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) pushWord(24'($urandom));
    tx_ready_for_first_read = 1'b1;
    rd0 = rd_count;
    for (int i = 0; i < 11; i++) ackOne(int'($urandom_range(0, 2)), b0);
    checkOutput("done_before_last", {31'b0, readout_done}, 32'd0);
    ackOne(0, b0);
    checkOutput("done_after_last", {31'b0, readout_done}, 32'd1);
    checkOutput("done_cnt", {10'b0, word_cnt}, 32'd4);
    checkOutput("done_reads", rd_count - rd0, 32'd4);
    checkOutput("fifo_left", fifo_q.size(), 32'd2);
    spi_byte_ack = 1'b1;
    tick();
    spi_byte_ack = 1'b0;
    checkOutput("done_ack_under", {31'b0, underrun}, 32'd1);
    repeat (10) tick();
    checkOutput("done_no_reads", rd_count - rd0, 32'd4);

    // Randomized rounds with spurious acks, late pushes and ready toggling.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (2) tick();
      flushFifo();
      tick();
      rst = 1'b0;
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) pushWord(24'($urandom));
      start = int'($urandom_range(0, 5));
      for (int c = 0; c < 200; c++) begin
        if (c < start) tx_ready_for_first_read = 1'b0;
        else if (c < start + 3) tx_ready_for_first_read = 1'b1;
        else tx_ready_for_first_read = 1'($urandom_range(0, 1));
        spi_byte_ack = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 19) == 0) pushWord(24'($urandom));
        tick();
      end
      spi_byte_ack = 1'b0;
      repeat (5) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tart_tx_readout.md
# tart_tx_readout

Drains the baseband transmit FIFO, filled from SDRAM by the acquisition/SDRAM scheduler, and presents its 24-bit antenna words to the SPI slave as a byte stream with a valid/ack handshake. It is the stage directly downstream of the scheduler's TX path. It starts only after the scheduler raises `tx_ready_for_first_read`, counts delivered words, and flags completion and host-side underruns.

## Interface
Parameters:
- `DATA_WIDTH`, 24: FIFO word width; must be a multiple of 8.
- `BYTES_PER_WORD`, 3: equals DATA_WIDTH/8.
- `TOTAL_WORDS`, 22'h1FFFFF: words to deliver before `readout_done`; matches the scheduler fill threshold.

Ports:
- `bb_clk`, in, 1: the single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `tx_ready_for_first_read`, in, 1: level from the scheduler; enables readout.
- `tx_empty`, in, 1: TX FIFO empty flag.
- `tx_rd_en`, out, 1: one-cycle FIFO read strobe.
- `tx_dout`, in, DATA_WIDTH: FIFO data, valid the cycle after `tx_rd_en` (standard read latency 1).
- `spi_byte`, out, 8: byte presented to the SPI slave.
- `spi_byte_valid`, out, 1: `spi_byte` is valid.
- `spi_byte_ack`, in, 1: one-cycle pulse; the SPI layer has consumed `spi_byte`. It is already synchronised to `bb_clk`.
- `word_cnt`, out, 22: count of words fully delivered.
- `readout_done`, out, 1: high once `word_cnt == TOTAL_WORDS`.
- `underrun`, out, 1: sticky flag; the host acked while no byte was valid.

## Operation
- States:
  - `IDLE`: wait for `tx_ready_for_first_read`.
  - `WAIT_DATA`: wait for `!tx_empty`.
  - `READ`: assert `tx_rd_en` for 1 cycle.
  - `LATCH`: capture `tx_dout` into the shift register and set `byte_idx = 0`.
  - `SEND`: drive the byte with `valid = 1`.
  - `DONE`: terminal state.
- Transitions:
  - `IDLE` → `WAIT_DATA` when `tx_ready_for_first_read = 1`.
  - `WAIT_DATA` → `READ` when `tx_empty = 0`.
  - `READ` → `LATCH` unconditionally.
  - `LATCH` → `SEND` unconditionally.
  - `SEND`, on `spi_byte_ack`, with `byte_idx < BYTES_PER_WORD-1`: shift left 8, `byte_idx++`, stay in `SEND`.
  - `SEND`, on `spi_byte_ack`, with the last byte: `word_cnt++`. Go to `DONE` if the new count equals `TOTAL_WORDS`, else go to `WAIT_DATA`.
- Byte order: MSB first. For 24 bits the bytes are `tx_dout[23:16]`, then `[15:8]`, then `[7:0]`.
- `spi_byte` is always the top byte of the shift register. It may be stale while `valid = 0`.
- `tx_rd_en` is asserted only in `READ` and never while `tx_empty = 1`. A FIFO overread cannot happen.
- `spi_byte_ack` while `spi_byte_valid = 0`: sets `underrun` (sticky until `rst`); state and counters are unchanged.
- `tx_ready_for_first_read` is sampled only in `IDLE`. Deassertion later has no effect.
- `DONE`: `valid = 0`, `readout_done = 1`, no further FIFO reads. Acks in this state set `underrun`.
- `word_cnt` is 22 bits and does not wrap, because `DONE` is reached first.

## Timing
- Reset values: `tx_rd_en = 0`, `spi_byte = 8'h00`, `spi_byte_valid = 0`, `word_cnt = 0`, `readout_done = 0`, `underrun = 0`, state `IDLE`. Reset mid-word discards any partial word.
- Latency from `!tx_empty` seen in `WAIT_DATA` to the first `spi_byte_valid`: 3 cycles (`READ`, `LATCH`, `SEND`).
- Byte-to-byte within a word: the next byte is valid the cycle after the ack. `valid` stays high throughout.
- Word-to-word with a non-empty FIFO: 4 cycles from the last-byte ack to the next `valid`.
- `spi_byte_valid` drops in the cycle following the last-byte ack.
- `readout_done` rises in the cycle after the final ack.
- All outputs are registered.

## Structure
- Package `tart_readout_pkg`:
  - state enumeration (3-bit encodings `IDLE = 0` … `DONE = 5`);
  - default `DATA_WIDTH`;
  - `TOTAL_WORDS`, shared with the scheduler fill threshold.
- One sub-module, `tart_word_shifter`: parallel-load, shift-by-8 register with `byte_idx` and a `last_byte` output. The FSM and counters stay in the top level.

## Test plan
- Preload FIFO with 24'hA1B2C3 and raise `tx_ready_for_first_read`. Expect `tx_rd_en` for exactly one cycle, then bytes A1, B2, C3 on successive acks, then `word_cnt = 1`.
- `tx_empty = 1` for 50 cycles after the first word. Expect no `tx_rd_en` and `valid = 0`. After data arrives, expect `valid` exactly 3 cycles after `tx_empty` falls.
- Ack pulse with `valid = 0`. Expect `underrun = 1`, held until `rst`, with `word_cnt` unchanged.
- `TOTAL_WORDS = 4` with 6 words in the FIFO. Expect exactly 4 reads, `readout_done = 1` the cycle after the 12th ack, and 2 words left in the FIFO.
- Assert `rst` after the second byte of a word. Next cycle expect all outputs at their reset values and state `IDLE`; readout restarts only on `tx_ready_for_first_read`.
- Ack held high for 3 consecutive cycles. Expect exactly 3 bytes consumed with no skips and no `underrun`.
